// File: rtl/clk_div_ctrl.sv
// Programmable CPU clock divider: clk_out with equal high/low phases of `half` clk cycles,
// a one-cycle clk_en at each rising toggle, run/halt/single-step control and a period counter.
module clk_div_ctrl #(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 1,
    parameter int PCNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  half_in,
    input  logic              half_load,
    input  logic              run,
    input  logic              step,
    output logic              clk_out,
    output logic              clk_en,
    output logic              halted,
    output logic              load_pend,
    output logic [PCNT_W-1:0] periods
);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    half_reg;
    logic [CNT_W-1:0]    pend_half_reg;
    logic                load_pend_reg;
    logic                clk_out_reg;
    logic                clk_en_reg;
    logic                halted_reg;
    logic [PCNT_W-1:0]   periods_reg;

    logic [CNT_W-1:0]    load_val;
    logic                at_end;
    logic                counting;
    logic                rise;
    logic                fall;

    always_comb begin
        load_val = (half_in == '0) ? CNT_W'(1) : half_in;
        at_end   = (cnt_reg == half_reg - CNT_W'(1));

        // A RUN state asked to stop while low halts immediately, so it must not count.
        counting = 1'b0;
        case (state_reg)
            S_RUN:           counting = run || clk_out_reg;
            S_STEP, S_DRAIN: counting = 1'b1;
            default:         counting = 1'b0;
        endcase

        rise = counting && at_end && !clk_out_reg;
        fall = counting && at_end && clk_out_reg;

        state_next = state_reg;
        case (state_reg)
            S_HALT: begin
                if (run)
                    state_next = S_RUN;
                else if (step)
                    state_next = S_STEP;
            end
            S_RUN: begin
                if (!run)
                    state_next = (!clk_out_reg || fall) ? S_HALT : S_DRAIN;
            end
            default: begin
                if (run)
                    state_next = S_RUN;
                else if (fall)
                    state_next = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_HALT;
            cnt_reg       <= '0;
            half_reg      <= CNT_W'(DEFAULT_HALF);
            pend_half_reg <= '0;
            load_pend_reg <= 1'b0;
            clk_out_reg   <= 1'b0;
            clk_en_reg    <= 1'b0;
            halted_reg    <= 1'b1;
            periods_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            halted_reg <= (state_next == S_HALT);
            clk_en_reg <= 1'b0;

            if (counting) begin
                if (at_end) begin
                    cnt_reg     <= '0;
                    clk_out_reg <= ~clk_out_reg;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                if (rise) begin
                    clk_en_reg  <= 1'b1;
                    periods_reg <= periods_reg + PCNT_W'(1);
                end
            end else begin
                cnt_reg     <= '0;
                clk_out_reg <= 1'b0;
            end

            // New half-periods only take effect at a falling toggle or while halted,
            // so a phase always runs for the half value it started with.
            if (state_reg == S_HALT) begin
                if (half_load) begin
                    pend_half_reg <= load_val;
                    load_pend_reg <= 1'b1;
                end else if (load_pend_reg) begin
                    half_reg      <= pend_half_reg;
                    load_pend_reg <= 1'b0;
                end
            end else if (fall) begin
                if (half_load)
                    half_reg <= load_val;
                else if (load_pend_reg)
                    half_reg <= pend_half_reg;
                load_pend_reg <= 1'b0;
            end else if (half_load) begin
                pend_half_reg <= load_val;
                load_pend_reg <= 1'b1;
            end
        end
    end

    assign clk_out   = clk_out_reg;
    assign clk_en    = clk_en_reg;
    assign halted    = halted_reg;
    assign load_pend = load_pend_reg;
    assign periods   = periods_reg;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: directed per-cycle vectors push expected outputs,
// a monitor pops and compares after every clock edge and after asynchronous reset.
module tb_clk_div_ctrl;

    localparam int CNT_W  = 8;
    localparam int PCNT_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [CNT_W-1:0]  half_in = '0;
    logic              half_load = 1'b0;
    logic              run = 1'b0;
    logic              step = 1'b0;
    logic              clk_out;
    logic              clk_en;
    logic              halted;
    logic              load_pend;
    logic [PCNT_W-1:0] periods;

    clk_div_ctrl #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (1),
        .PCNT_W       (PCNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .half_in   (half_in),
        .half_load (half_load),
        .run       (run),
        .step      (step),
        .clk_out   (clk_out),
        .clk_en    (clk_en),
        .halted    (halted),
        .load_pend (load_pend),
        .periods   (periods)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]        sid;
        logic [7:0]        idx;
        logic              out;
        logic              en;
        logic              halt;
        logic              pend;
        logic [PCNT_W-1:0] per;
    } exp_t;

    exp_t              sb_q[$];
    int                applied = 0;
    int                miscompares = 0;
    logic [PCNT_W-1:0] exp_per = '0;

    function automatic string sname(input logic [3:0] sid);
        case (sid)
            4'd0:    return "reset";
            4'd1:    return "run_half1";
            4'd2:    return "load_at_fall";
            4'd3:    return "load_mid_high";
            4'd4:    return "drain_half4";
            4'd5:    return "load0_step";
            4'd6:    return "step_half2";
            4'd7:    return "period_wrap";
            4'd8:    return "after_reset";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic ch(input string s, input int i);
        return (s.getc(i) == 8'h31);
    endfunction

    task automatic push_reset_vec(input logic [3:0] sid);
        exp_t e;
        e.sid  = sid;
        e.idx  = 8'd0;
        e.out  = 1'b0;
        e.en   = 1'b0;
        e.halt = 1'b1;
        e.pend = 1'b0;
        e.per  = '0;
        sb_q.push_back(e);
    endtask

    // Called just after a negedge; each character is one clk cycle, expected values are after that edge.
    task automatic scen(input logic [3:0] sid, input string run_s, input string step_s,
                        input string load_s, input int hval, input string out_s,
                        input string en_s, input string halt_s, input string pend_s);
        for (int i = 0; i < out_s.len(); i++) begin
            exp_t e;
            run       = ch(run_s, i);
            step      = ch(step_s, i);
            half_load = ch(load_s, i);
            half_in   = CNT_W'(hval);
            if (ch(en_s, i))
                exp_per = exp_per + PCNT_W'(1);
            e.sid  = sid;
            e.idx  = 8'(i);
            e.out  = ch(out_s, i);
            e.en   = ch(en_s, i);
            e.halt = ch(halt_s, i);
            e.pend = ch(pend_s, i);
            e.per  = exp_per;
            sb_q.push_back(e);
            @(negedge clk);
        end
    endtask

    initial begin
        forever begin
            exp_t e;
            @(posedge clk or posedge reset);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                applied++;
                if ({clk_out, clk_en, halted, load_pend, periods} !==
                    {e.out, e.en, e.halt, e.pend, e.per}) begin
                    miscompares++;
                    $display("FAIL %s[%0d]: out/en/halted/pend/periods got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                             sname(e.sid), e.idx, clk_out, clk_en, halted, load_pend, periods,
                             e.out, e.en, e.halt, e.pend, e.per);
                end else begin
                    $display("vec %s[%0d] ok: out=%b en=%b halted=%b pend=%b periods=%0d",
                             sname(e.sid), e.idx, clk_out, clk_en, halted, load_pend, periods);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        push_reset_vec(4'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        scen(4'd1, "1111111111", "0000000000", "0000000000", 0,
             "0101010101", "0101010101", "0000000000", "0000000000");
        scen(4'd2, "11111", "00000", "10000", 4,
             "00001", "00001", "00000", "00000");
        scen(4'd3, "1111111111", "0000000000", "1000000000", 3,
             "1110001110", "0000001000", "0000000000", "1110000000");
        scen(4'd4, "1111111111000000", "0000000000000000", "1000000000000000", 4,
             "0011100001111000", "0010000001000000", "0000000000000111", "1111100000000000");
        scen(4'd5, "00000", "00100", "10000", 0,
             "00010", "00010", "11001", "10000");
        scen(4'd6, "000000000", "001001000", "100000000", 2,
             "000011000", "000010000", "110000111", "100000000");
        scen(4'd7, "11111111111111111111", "00000000000000000000", "00000000000000000001", 3,
             "00110011001100110011", "00100010001000100010", "00000000000000000000",
             "00000000000000000001");

        // clk_out is high and a load is pending here; reset must clear both before the next edge.
        #2;
        run       = 1'b0;
        step      = 1'b0;
        half_load = 1'b0;
        reset     = 1'b1;
        exp_per   = '0;
        push_reset_vec(4'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        scen(4'd8, "111111", "000000", "000000", 0,
             "010101", "010101", "000000", "000000");

        run = 1'b0;
        @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left unchecked, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Parametrised successor to the fixed divide-by-2 CPU clock stage in the single-cycle CPU top level.
- Generates a divided CPU clock `clk_out` and a matching one-cycle enable `clk_en` from `clk`.
- Half-period is programmable at runtime, with glitch-free reload at period boundaries.
- Adds run/halt control, single-step for debug, and a period counter.

Parameters:
- CNT_W, 16, width of half-period register and phase counter.
- DEFAULT_HALF, 1, half-period in clk cycles after reset (1 = divide-by-2).
- PCNT_W, 32, width of the completed-period counter.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- half_in  in  CNT_W  requested half-period in clk cycles; 0 is coerced to 1.
- half_load  in  1  one-cycle strobe; captures half_in as pending.
- run  in  1  level; 1 = free-run, 0 = halt at the next low phase.
- step  in  1  one-cycle strobe; honoured only in HALT with run=0.
- clk_out  out  1  divided clock; registered.
- clk_en  out  1  high during the first clk cycle of each clk_out high phase.
- halted  out  1  high while in HALT.
- load_pend  out  1  a loaded half-period is waiting for a boundary.
- periods  out  PCNT_W  count of clk_out rising toggles; wraps to 0.

Behaviour:
- Reset values:
  - state=HALT, clk_out=0, clk_en=0, halted=1, load_pend=0, periods=0.
  - cnt=0, half=DEFAULT_HALF.
- States are HALT, RUN, STEP, DRAIN. cnt is held at 0 in HALT.
- Active states (RUN, STEP, DRAIN):
  - If cnt==half-1: clk_out toggles and cnt<=0; otherwise cnt increments.
  - Each high phase and each low phase lasts exactly `half` clk cycles.
- Rising toggle: periods increments (modulo 2^PCNT_W) and clk_en=1 for that one cycle. clk_en is 0 in all other cycles.
- HALT:
  - run=1 -> RUN; run has priority over step.
  - step=1 with run=0 -> STEP.
  - Otherwise stay in HALT, with clk_out=0.
  - First rising toggle happens `half` cycles after the state leaves HALT.
- RUN:
  - run=0 with clk_out=0 -> HALT at the next edge; cnt cleared; clk_out stays 0.
  - run=0 with clk_out=1 -> DRAIN.
- DRAIN:
  - Counting continues; at the falling toggle -> HALT.
  - run re-asserted -> RUN with no phase disturbance.
- STEP:
  - Produces exactly one full period: `half` cycles low, rise, `half` cycles high, fall -> HALT.
  - run asserted during STEP -> RUN with no phase disturbance.
  - step pulses while not in HALT are ignored and are not queued.
- Half-period reload:
  - half_load stores max(half_in,1) in pending and sets load_pend.
  - Pending is applied at the next falling toggle, or on the next edge while in HALT. load_pend then clears.
  - half_load in the same cycle as a falling toggle is applied at that toggle.
  - A second half_load before it is applied overwrites pending; only the last value is used.
- clk_out never produces a phase shorter than the half value in force at the start of that phase. No glitches or runt pulses under any run/step/load sequence.
- Reset asserted mid-phase drops clk_out to 0 immediately (asynchronously) and discards pending.

Test Plan:
- Reset release with run=1, half=1 (default):
  - clk_out=0 for 2 edges, then toggles every clk.
  - clk_en high on every other cycle, coincident with clk_out=1.
  - periods=5 after 5 rises.
- run=1, half_load with half_in=3 mid-high-phase:
  - Current period completes at the old half.
  - New period is 3 cycles high / 3 cycles low.
  - load_pend is 1 from the load until the falling toggle.
- half=4, run dropped 1 cycle into a high phase:
  - clk_out stays high 3 more cycles, falls, then halted=1 and clk_out holds 0.
  - No further clk_en.
- In HALT with half=2, step pulse:
  - clk_out low 2 cycles, high 2 cycles, low, halted=1.
  - Exactly one clk_en; periods +1.
  - A second step during the period is ignored.
- half_in=0 loaded while halted:
  - half becomes 1 next edge; load_pend returns to 0.
- periods preset near wrap (PCNT_W=4, 15 rises):
  - The 16th rise reads 0.
- Reset pulse mid high phase:
  - clk_out=0 asynchronously, halted=1, half=DEFAULT_HALF.
